// File: rtl/dwram_fetch_queue.sv
// Fetches a run of double-width pairs from a 1-cycle-latency RAM into a small
// output queue. Optional return-data bypass: DWRAM_FETCH_QUEUE_BYPASS_EN.
module dwram_fetch_queue #(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 256,
  parameter  int QDEPTH = 4,
  localparam int PA     = $clog2(DEPTH) - 1
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [PA-1:0]        req_addr,
  input  logic [PA:0]          req_count,

  output logic                 ram_enb,
  output logic [PA-1:0]        ram_addrb,
  input  logic [2*WIDTH-1:0]   ram_doutb,

  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_data,
  output logic                 out_last,

  input  logic                 flush,
  output logic                 busy
);

  // state | meaning
  // IDLE  | no request active; accepts a new request
  // RUN   | issuing reads while queue credit allows
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int QA = $clog2(QDEPTH);

  state_t              state_q, state_d;
  logic [PA-1:0]       addr_q, addr_d;
  logic [PA:0]         rem_q, rem_d;
  logic                inflight_q;
  logic                inflight_last_q;
  logic [QA:0]         occ_q, occ_d;
  logic [QA-1:0]       wr_ptr_q, rd_ptr_q;
  logic [2*WIDTH-1:0]  mem_data_q [QDEPTH];
  logic                mem_last_q [QDEPTH];

  logic credit;
  logic issue;
  logic hs;
  logic q_valid;
  logic byp_avail;
  logic push;
  logic pop;

  assign credit  = (occ_q + (QA+1)'(inflight_q)) < (QA+1)'(QDEPTH);
  assign issue   = !rst && !flush && (state_q == RUN) && credit;
  assign ram_enb = issue;
  assign ram_addrb = addr_q;

  assign req_ready = !rst && !flush && (state_q == IDLE);
  assign hs        = req_valid && req_ready;

  assign q_valid = (occ_q != '0);
`ifdef DWRAM_FETCH_QUEUE_BYPASS_EN
  assign byp_avail = inflight_q && !q_valid;
`else
  assign byp_avail = 1'b0;
`endif

  assign out_valid = !rst && !flush && (q_valid || byp_avail);
  assign pop       = out_valid && out_ready && q_valid;
  // A bypassed pair that the consumer takes this cycle never enters the queue.
  assign push      = inflight_q && !rst && !flush && !(byp_avail && out_ready);

  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    if (out_valid) begin
      if (q_valid) begin
        out_data = mem_data_q[rd_ptr_q];
        out_last = mem_last_q[rd_ptr_q];
      end else begin
        out_data = ram_doutb;
        out_last = inflight_last_q;
      end
    end
  end

  assign busy = !rst && ((state_q == RUN) || inflight_q || q_valid);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (hs && (req_count != '0)) begin
          state_d = RUN;
          addr_d  = req_addr;
          rem_d   = req_count;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d = addr_q + PA'(1);
          rem_d  = rem_q - (PA+1)'(1);
          if (rem_q == (PA+1)'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      rem_d   = '0;
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + (QA+1)'(1);
      2'b01:   occ_d = occ_q - (QA+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      occ_q           <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (rem_q == (PA+1)'(1));
      if (flush) begin
        occ_q    <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        occ_q <= occ_d;
        if (push) wr_ptr_q <= wr_ptr_q + QA'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + QA'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= ram_doutb;
      mem_last_q[wr_ptr_q] <= inflight_last_q;
    end
  end

endmodule
